// File: rtl/jtcop_obj_linedraw.sv
// Sprite line drawer: fetches 4bpp planar tile rows from the object ROM and
// draws them into a ping-pong line buffer whose other half is scanned out and erased.
module jtcop_obj_linedraw #(
  parameter int unsigned CW    = 13,
  parameter int unsigned PW    = 4,
  parameter int unsigned AW    = 9,
  parameter logic [3:0]  ALPHA = 4'h0
)(
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          draw,
  output logic          busy,
  input  logic [CW-1:0] code,
  input  logic [AW-1:0] xpos,
  input  logic [3:0]    ysub,
  input  logic          size16,
  input  logic          hflip,
  input  logic [PW-1:0] pal,
  output logic          rom_cs,
  output logic [CW+4:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,
  output logic [PW+3:0] pxl
);
  localparam int unsigned PXW   = PW + 4;
  localparam int unsigned DEPTH = 2**(AW+1);
  localparam logic [PXW-1:0] BLANK = {PW'(0), ALPHA};

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t          state, state_nx;
  logic            busy_nx, rom_cs_nx, rom_good, rom_good_nx;
  logic [CW+4:0]   rom_addr_nx;
  logic [31:0]     data, data_nx;
  logic [2:0]      cnt, cnt_nx;
  logic            half, half_nx;
  logic            accept, we;

  logic [AW-1:0]   l_xpos;
  logic            l_size16, l_hflip;
  logic [PW-1:0]   l_pal;
  logic            draw_bank, disp_bank, lhbl_l, swap;

  logic [2:0]      sel;
  logic [3:0]      pen;
  logic [AW-1:0]   wr_addr;

  logic [PXW-1:0]  mem [DEPTH];

  // Mirroring just reverses the column index inside each plane byte
  assign sel     = l_hflip ? ~cnt : cnt;
  assign pen     = {data[{2'b10, sel}], data[{2'b11, sel}], data[{2'b00, sel}], data[{2'b01, sel}]};
  assign wr_addr = l_xpos + AW'({half, cnt});
  assign swap    = lhbl_l & ~LHBL;

  // Next-state and registered-output logic
  always_comb begin
    state_nx    = state;
    busy_nx     = busy;
    rom_cs_nx   = rom_cs;
    rom_addr_nx = rom_addr;
    rom_good_nx = rom_ok;
    data_nx     = data;
    cnt_nx      = cnt;
    half_nx     = half;
    accept      = 1'b0;
    we          = 1'b0;
    case (state)
      IDLE: begin
        if (draw) begin
          accept      = 1'b1;
          state_nx    = FETCH;
          busy_nx     = 1'b1;
          rom_cs_nx   = 1'b1;
          rom_addr_nx = {code, size16 & hflip, size16 ? ysub : {1'b0, ysub[2:0]}};
          rom_good_nx = 1'b0;
          half_nx     = 1'b0;
        end
      end
      FETCH: begin
        // rom_good keeps a stale rom_ok from the previous address from being taken
        if (rom_good && rom_ok) begin
          data_nx   = rom_data;
          rom_cs_nx = 1'b0;
          cnt_nx    = 3'd0;
          state_nx  = WRITE;
        end
      end
      WRITE: begin
        we     = (pen != ALPHA);
        cnt_nx = 3'(cnt + 3'd1);
        if (cnt == 3'd7) begin
          if (l_size16 && !half) begin
            state_nx       = FETCH;
            half_nx        = 1'b1;
            rom_cs_nx      = 1'b1;
            rom_addr_nx[4] = ~l_hflip;
            rom_good_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      rom_good <= 1'b0;
      data     <= '0;
      cnt      <= 3'd0;
      half     <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= busy_nx;
      rom_cs   <= rom_cs_nx;
      rom_addr <= rom_addr_nx;
      rom_good <= rom_good_nx;
      data     <= data_nx;
      cnt      <= cnt_nx;
      half     <= half_nx;
    end
  end

  // Request parameters and drawing bank, frozen for the whole tile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_xpos    <= '0;
      l_size16  <= 1'b0;
      l_hflip   <= 1'b0;
      l_pal     <= '0;
      draw_bank <= 1'b1;
    end else if (accept) begin
      l_xpos    <= xpos;
      l_size16  <= size16;
      l_hflip   <= hflip;
      l_pal     <= pal;
      draw_bank <= ~(disp_bank ^ swap);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_l    <= 1'b0;
      disp_bank <= 1'b0;
    end else begin
      lhbl_l <= LHBL;
      if (swap) disp_bank <= ~disp_bank;
    end
  end

  // Scan-out read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl <= BLANK;
    end else if (!LHBL) begin
      pxl <= BLANK;
    end else if (pxl_cen) begin
      pxl <= mem[{disp_bank, hdump}];
    end
  end

  // Line buffer: draw into one bank, erase behind the read in the other
  always_ff @(posedge clk) begin
    if (we) mem[{draw_bank, wr_addr}] <= {l_pal, pen};
    if (pxl_cen && LHBL) mem[{disp_bank, hdump}] <= BLANK;
  end

endmodule

// File: tb/tb_jtcop_obj_linedraw.sv
// Directed bench for jtcop_obj_linedraw: draws tiles, swaps banks and reads them back.
module tb_jtcop_obj_linedraw;
  logic        rst, clk, pxl_cen, LHBL, draw, busy, size16, hflip, rom_cs, rom_ok;
  logic [8:0]  hdump, xpos;
  logic [12:0] code;
  logic [3:0]  ysub, pal;
  logic [17:0] rom_addr;
  logic [31:0] rom_data, rom_d0, rom_d1;
  logic [7:0]  pxl;
  int n_chk, n_fail;

  jtcop_obj_linedraw dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .draw(draw), .busy(busy), .code(code), .xpos(xpos), .ysub(ysub),
    .size16(size16), .hflip(hflip), .pal(pal), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
  );

  // ROM model: the h bit of the address selects one of two words
  assign rom_data = rom_addr[4] ? rom_d1 : rom_d0;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_draw(input logic [12:0] c, input logic [8:0] x, input logic [3:0] y,
                            input logic s16, input logic hf, input logic [3:0] p);
    code = c; xpos = x; ysub = y; size16 = s16; hflip = hf; pal = p;
    draw = 1'b1;
    tick;
    draw = 1'b0;
  endtask

  task automatic run_to_idle(input int from, output int fe);
    fe = -1;
    for (int k = from; k <= from + 60; k++) begin
      tick;
      if (!busy) begin
        fe = k;
        break;
      end
    end
  endtask

  task automatic swap_banks;
    LHBL = 1'b0;
    tick;
    tick;
    LHBL = 1'b1;
    tick;
  endtask

  task automatic read_px(input logic [8:0] a, output logic [7:0] v);
    hdump = a;
    pxl_cen = 1'b1;
    tick;
    v = pxl;
    pxl_cen = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    n_chk++;
    if (busy !== 1'b0 || rom_cs !== 1'b0 || rom_addr !== 18'h0 || pxl !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: busy=%b rom_cs=%b rom_addr=%h pxl=%h, need 0 0 00000 00", busy, rom_cs, rom_addr, pxl);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_draw8;
    logic [7:0] v, e;
    int fe;
    rom_d0 = 32'h0F0F00FF; rom_d1 = 32'hDEADBEEF; rom_ok = 1'b1;
    start_draw(13'h123, 9'h040, 4'h5, 1'b0, 1'b0, 4'h3);
    n_chk++;
    if (rom_addr !== 18'h02465 || busy !== 1'b1 || rom_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL draw8_fetch: addr=%h busy=%b cs=%b, need 02465 1 1", rom_addr, busy, rom_cs);
    end
    tick;
    tick;
    n_chk++;
    if (rom_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL draw8_cs_drop: rom_cs=%b after latch edge, need 0", rom_cs);
    end
    run_to_idle(3, fe);
    n_chk++;
    if (fe != 10) begin
      n_fail++;
      $display("FAIL draw8_busy: busy fell after edge %0d, need 10", fe);
    end
    swap_banks;
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h040 + i), v);
      e = (i < 4) ? 8'h3E : 8'h32;
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL draw8_px%0d: got %h need %h", i, v, e);
      end
    end
  endtask

  task automatic test_hflip;
    logic [7:0] v, e;
    int fe;
    start_draw(13'h123, 9'h040, 4'hD, 1'b0, 1'b1, 4'h3);
    n_chk++;
    if (rom_addr !== 18'h02465) begin
      n_fail++;
      $display("FAIL hflip_addr: got %h need 02465", rom_addr);
    end
    tick;
    tick;
    run_to_idle(3, fe);
    n_chk++;
    if (fe != 10) begin
      n_fail++;
      $display("FAIL hflip_busy: busy fell after edge %0d, need 10", fe);
    end
    swap_banks;
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h040 + i), v);
      e = (i < 4) ? 8'h32 : 8'h3E;
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL hflip_px%0d: got %h need %h", i, v, e);
      end
    end
  endtask

  task automatic test_draw16_wrap;
    logic [7:0] v, e;
    int fe;
    rom_d1 = 32'h0F0F00FF; rom_d0 = 32'hFFFFFFFF;
    start_draw(13'h0AB, 9'h1FC, 4'hA, 1'b1, 1'b1, 4'h5);
    n_chk++;
    if (rom_addr !== 18'h0157A) begin
      n_fail++;
      $display("FAIL d16_addr1: got %h need 0157A", rom_addr);
    end
    for (int k = 1; k <= 10; k++) tick;
    n_chk++;
    if (rom_addr !== 18'h0156A || rom_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL d16_addr2: addr=%h cs=%b need 0156A 1", rom_addr, rom_cs);
    end
    run_to_idle(11, fe);
    n_chk++;
    if (fe != 20) begin
      n_fail++;
      $display("FAIL d16_busy: busy fell after edge %0d, need 20", fe);
    end
    swap_banks;
    for (int k = 0; k < 16; k++) begin
      read_px(9'(9'h1FC + k), v);
      e = (k >= 8) ? 8'h5F : ((k < 4) ? 8'h52 : 8'h5E);
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL d16_px%0d: got %h need %h", k, v, e);
      end
    end
  endtask

  task automatic test_stale_ok;
    logic [7:0] v, e;
    int fe;
    rom_d0 = 32'hFFFFFFFF; rom_ok = 1'b1;
    start_draw(13'h200, 9'h100, 4'h3, 1'b0, 1'b0, 4'h7);
    tick;
    rom_ok = 1'b0;
    tick;
    tick;
    tick;
    rom_ok = 1'b1;
    tick;
    rom_d0 = 32'h0F0F00FF;
    n_chk++;
    if (rom_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_first_ok: rom_cs=%b on first ok edge, need 1", rom_cs);
    end
    tick;
    n_chk++;
    if (rom_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_second_ok: rom_cs=%b on second ok edge, need 0", rom_cs);
    end
    run_to_idle(7, fe);
    n_chk++;
    if (fe != 14) begin
      n_fail++;
      $display("FAIL stale_busy: busy fell after edge %0d, need 14", fe);
    end
    swap_banks;
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h100 + i), v);
      e = (i < 4) ? 8'h7E : 8'h72;
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL stale_px%0d: got %h need %h", i, v, e);
      end
    end
  endtask

  task automatic test_overlap;
    logic [7:0] v, e;
    int fe;
    rom_d0 = 32'hFFFFFFFF;
    start_draw(13'h010, 9'h0C0, 4'h0, 1'b0, 1'b0, 4'h1);
    run_to_idle(1, fe);
    tick;
    rom_d0 = 32'h00AA0000;
    start_draw(13'h011, 9'h0C0, 4'h0, 1'b0, 1'b0, 4'h2);
    run_to_idle(1, fe);
    n_chk++;
    if (fe != 10) begin
      n_fail++;
      $display("FAIL overlap_busy: busy fell after edge %0d, need 10", fe);
    end
    swap_banks;
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h0C0 + i), v);
      e = (i % 2 == 0) ? 8'h1F : 8'h28;
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL overlap_px%0d: got %h need %h", i, v, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h0C0 + i), v);
      n_chk++;
      if (v !== 8'h00) begin
        n_fail++;
        $display("FAIL erased_px%0d: got %h need 00", i, v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v, e;
    int fe;
    rom_d0 = 32'hFFFFFFFF;
    start_draw(13'h011, 9'h020, 4'h0, 1'b0, 1'b0, 4'h4);
    tick;
    tick;
    code = 13'h1FF; xpos = 9'h024; pal = 4'h9; draw = 1'b1;
    tick;
    draw = 1'b0;
    n_chk++;
    if (rom_addr !== 18'h00220) begin
      n_fail++;
      $display("FAIL b2b_ignore_busy: addr=%h need 00220", rom_addr);
    end
    repeat (6) tick;
    draw = 1'b1;
    tick;
    draw = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_fall_cycle: busy=%b after edge 10, need 0", busy);
    end
    start_draw(13'h012, 9'h028, 4'h0, 1'b0, 1'b0, 4'hA);
    n_chk++;
    if (busy !== 1'b1 || rom_addr !== 18'h00240) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b addr=%h need 1 00240", busy, rom_addr);
    end
    tick;
    tick;
    run_to_idle(3, fe);
    swap_banks;
    for (int k = 0; k < 16; k++) begin
      read_px(9'(9'h020 + k), v);
      e = (k < 8) ? 8'h4F : 8'hAF;
      n_chk++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL b2b_px%0d: got %h need %h", k, v, e);
      end
    end
  endtask

  task automatic test_reset_and_swap;
    logic [7:0] v;
    int fe;
    rom_ok = 1'b0;
    start_draw(13'h005, 9'h060, 4'h1, 1'b0, 1'b0, 4'h2);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || rom_cs !== 1'b0 || rom_addr !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_fetch: busy=%b cs=%b addr=%h need 0 0 00000", busy, rom_cs, rom_addr);
    end
    #2 rst = 1'b0;
    tick;
    rom_ok = 1'b1; rom_d0 = 32'hFFFFFFFF;
    start_draw(13'h005, 9'h060, 4'h1, 1'b0, 1'b0, 4'h2);
    repeat (5) tick;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write: busy=%b need 0", busy);
    end
    #2 rst = 1'b0;
    tick;
    start_draw(13'h030, 9'h080, 4'h0, 1'b0, 1'b0, 4'h6);
    repeat (4) tick;
    LHBL = 1'b0;
    tick;
    n_chk++;
    if (pxl !== 8'h00) begin
      n_fail++;
      $display("FAIL blank_pxl: got %h need 00", pxl);
    end
    tick;
    LHBL = 1'b1;
    run_to_idle(7, fe);
    n_chk++;
    if (fe != 10) begin
      n_fail++;
      $display("FAIL swap_busy: busy fell after edge %0d, need 10", fe);
    end
    for (int i = 0; i < 8; i++) begin
      read_px(9'(9'h080 + i), v);
      n_chk++;
      if (v !== 8'h6F) begin
        n_fail++;
        $display("FAIL swap_px%0d: got %h need 6f", i, v);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; hdump = '0; draw = 1'b0;
    code = '0; xpos = '0; ysub = '0; size16 = 1'b0; hflip = 1'b0; pal = '0;
    rom_ok = 1'b0; rom_d0 = '0; rom_d1 = '0;
    n_chk = 0; n_fail = 0;
    test_reset;
    test_draw8;
    test_hflip;
    test_draw16_wrap;
    test_stale_ok;
    test_overlap;
    test_back_to_back;
    test_reset_and_swap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
